pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
- REQ-001: Parameter WIDTH, default 8, data width in bits; legal range 1..64.
- REQ-002: Parameter STAGES, default 3, number of register stages; legal range 1..16.
- REQ-003: Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data register on reset.
- REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005: rst  input  1  asynchronous, active-high reset.
- REQ-006: flush  input  1  synchronous clear of all stage valid bits.
- REQ-007: in_valid  input  1  upstream beat present.
- REQ-008: in_data  input  WIDTH  upstream beat payload.
- REQ-009: in_ready  output  1  pipe accepts the beat this cycle.
- REQ-010: out_valid  output  1  stage STAGES-1 holds a beat.
- REQ-011: out_data  output  WIDTH  payload of stage STAGES-1.
- REQ-012: out_ready  input  1  downstream accepts the beat this cycle.
- REQ-013: count  output  $clog2(STAGES+1)  number of occupied stages.

Function
- REQ-014: The block SHALL contain STAGES stages, each holding a WIDTH-bit data register and a valid bit v[i]; stage 0 is the input end and stage STAGES-1 the output end.
- REQ-015: Stage readiness SHALL be combinational: r[STAGES-1] = !v[STAGES-1] | out_ready; r[i] = !v[i] | r[i+1] for i < STAGES-1.
- REQ-016: in_ready SHALL equal r[0] & !flush.
- REQ-017: A beat SHALL be accepted on a rising edge when in_valid & in_ready; it is then loaded into stage 0.
- REQ-018: When r[i+1] is 1, stage i+1 SHALL load data and valid from stage i; bubbles collapse, so an empty stage always fills when its predecessor is valid.
- REQ-019: Stage STAGES-1 SHALL be emptied on an edge with out_valid & out_ready, unless it is refilled on the same edge.
- REQ-020: A data register SHALL hold its value when it does not load; data values SHALL never be modified in flight.
- REQ-021: out_valid SHALL equal v[STAGES-1] and out_data SHALL equal the stage STAGES-1 data register, with no combinational path from in_data.
- REQ-022: Once out_valid is 1, out_valid and out_data SHALL stay stable until the cycle in which out_ready is 1.
- REQ-023: Latency SHALL be STAGES cycles: on an empty pipe with out_ready=1, a beat accepted at edge k SHALL be presented on out_valid/out_data after edge k+STAGES-1.
- REQ-024: Throughput SHALL be one beat per cycle while in_valid=1 and out_ready=1, with no bubbles inserted.
- REQ-025: When full (count=STAGES) and out_ready=0, in_ready SHALL be 0; when full and out_ready=1, in_ready SHALL be 1 and accept and emit SHALL occur on the same edge.
- REQ-026: flush=1 SHALL clear every v[i] on the next edge and SHALL take priority over accept, advance and emit on that edge; data registers are not altered by flush.
- REQ-027: count SHALL equal the population count of v[]; it SHALL be derived from registered state only.
- REQ-028: STAGES=1 SHALL behave as a single-entry register slice that passes through when out_ready=1 (full-throughput, in_ready depends on out_ready).

Reset
- REQ-029: While rst=1, all v[i] SHALL be 0, all data registers SHALL be RESET_VAL, out_valid=0, count=0 and in_ready=0, independent of clk.
- REQ-030: rst asserted mid-transfer SHALL discard all held beats immediately; after deassertion in_ready SHALL be 1 (if flush=0) on the first cycle.

Verification (WIDTH=8, STAGES=3, RESET_VAL=8'h00)
- REQ-031: Reset -> out_valid=0, out_data=8'h00, count=0; after release in_ready=1.
- REQ-032: out_ready=1, in_data 8'h11 presented with in_valid for 1 cycle at edge 0 -> out_valid=1 with out_data=8'h11 after edge 2, low after edge 3.
- REQ-033: out_ready=1, stream 8'h01..8'h08 on consecutive cycles -> same sequence on consecutive output cycles, no gaps, count peaks at 3.
- REQ-034: out_ready=0, send 8'hA1,8'hA2,8'hA3,8'hA4 -> first three accepted, count=3, in_ready=0, A4 held; raise out_ready -> A1,A2,A3,A4 in order, out_data stable while stalled.
- REQ-035: Pipe holding 2 beats, flush=1 with in_valid=1 for one cycle -> in_ready=0 that cycle, count=0 and out_valid=0 after the edge, input beat not accepted.
- REQ-036: rst pulsed asynchronously between edges while count=3 -> out_valid and count drop to 0 before the next edge, no stale beat emitted afterward.

Source files
------------

// File: rtl/pipe_reg.sv
// Elastic pipeline register of STAGES stages with valid/ready handshake,
// bubble collapsing, synchronous flush and occupancy count.
module pipe_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           STAGES    = 3,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             out_ready,
    output logic [$clog2(STAGES+1)-1:0]      count
);

    localparam int unsigned CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_nxt;
    logic [STAGES-1:0] r;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  data [STAGES];
    logic [CW-1:0]     cnt_nxt;

    // Ready ripples from the output end: a stage can take a beat if it is
    // empty or if everything downstream of it moves this cycle.
    always_comb begin
        logic rr;
        r  = '0;
        rr = !v[STAGES-1] | out_ready;
        r[STAGES-1] = rr;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            rr   = !v[i] | rr;
            r[i] = rr;
        end
    end

    assign in_ready  = r[0] & !flush & !rst;
    assign out_valid = v[STAGES-1];
    assign out_data  = data[STAGES-1];

    // Next valid vector and data-load enables; flush wins over all movement.
    always_comb begin
        v_nxt = v;
        ld    = '0;
        if (!flush) begin
            if (r[0]) begin
                v_nxt[0] = in_valid;
                ld[0]    = in_valid;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (r[i]) begin
                    v_nxt[i] = v[i-1];
                    ld[i]    = v[i-1];
                end
            end
        end else begin
            v_nxt = '0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
        end
    end

    // Data only moves when a real beat moves, so payloads never change in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                data[i] <= RESET_VAL;
            end
        end else begin
            v     <= v_nxt;
            count <= cnt_nxt;
            if (ld[0]) begin
                data[0] <= in_data;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (ld[i]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed scoreboard bench for pipe_reg (WIDTH=8, STAGES=3).
module tb_pipe_reg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 3;
    localparam int unsigned CW     = $clog2(STAGES + 1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;
    int peak   = 0;

    logic [WIDTH-1:0] sb [$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    pipe_reg #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the negedge, update the model for the coming edge.
    task automatic tick();
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
        check("count_vs_model", 32'(count), 32'(sb.size()));
        if (int'(count) > peak) peak = int'(count);
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
        end
        prev_stall = out_valid & !out_ready & !flush;
        prev_data  = out_data;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_d = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(exp_d));
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat latency
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        check("lat_edge0_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        check("lat_edge2_data", 32'(out_data), 32'h11);
        tick();
        check("lat_edge3_valid", 32'(out_valid), 32'd0);
        check("lat_drained", 32'(sb.size()), 32'd0);

        // Full-throughput stream
        peak = 0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("stream_no_gaps", 32'(sb.size()), 32'd0);
        check("stream_peak", 32'(peak), 32'd3);
        check("stream_out_valid_end", 32'(out_valid), 32'd0);

        // Backpressure: three accepted, fourth held
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick();
        in_data = 8'hA4;
        check("full_count", 32'(count), 32'd3);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_data", 32'(out_data), 32'hA1);
        tick(); tick();
        check("held_count", 32'(count), 32'd3);
        check("held_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("full_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("full_swap_count", 32'(count), 32'd3);
        tick(); tick(); tick(); tick();
        check("bp_drained", 32'(sb.size()), 32'd0);
        check("bp_out_valid_end", 32'(out_valid), 32'd0);

        // Flush with a competing input beat
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1; tick();
        in_data = 8'hB2; tick();
        check("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1; in_data = 8'hC3;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("flush_no_ghost", 32'(out_valid), 32'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hD1; tick();
        in_data = 8'hD2; tick();
        in_data = 8'hD3; tick();
        in_valid = 1'b0;
        check("pre_arst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_out_data", 32'(out_data), 32'h00);
        sb.delete();
        prev_stall = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("arst_release_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("arst_no_stale", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
